maindec_mc: RTL and testbench
=============================

Name: maindec_mc

Overview:
- Multi-cycle successor to the single-cycle main decoder; sits in the control unit between the instruction register opcode field and the datapath.
- Sequences each LEGv8 instruction through FETCH/DECODE/EXEC/MEM/WB states, emitting per-state strobes. Adds configurable memory wait states, ERET, and exception entry for invalid opcodes and external interrupts, with a latched EStatus code.

Parameters:
- OP_W, 11, opcode width; decode compares Op[OP_W-1 -: 11].
- MEM_WAIT, 0, extra stall cycles spent in MEM (0..15).
- IRQ_EN, 1, 1 enables ExtIRQ exception entry; 0 ignores ExtIRQ.
- ES_W, 4, EStatus width (>=2).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- Op  in  OP_W  opcode from instruction register, valid from DECODE onward
- ExtIRQ  in  1  level interrupt request
- IRWrite  out  1  load instruction register
- PCWrite  out  1  PC update strobe
- Reg2Loc, ALUSrc, MemtoReg  out  1 each  datapath selects, from decode latch
- RegWrite, MemRead, MemWrite, Branch  out  1 each  strobes
- ALUOp  out  2  ALU operation class, from decode latch
- ERet  out  1  return-from-exception strobe
- Exc  out  1  exception entry strobe
- EStatus  out  ES_W  exception cause, registered
- Busy  out  1  0 only in FETCH

Behaviour:
- Reset: state=FETCH, wait counter=0, decode latch=0, EStatus=0. While reset=1, every strobe output and Busy is 0. The first cycle after release is FETCH. Reset mid-instruction aborts it with no further strobes.
- Decode latch is captured at the end of DECODE. It holds class (R, LDUR, STUR, CBZ, ERET, INV), Reg2Loc, ALUSrc, MemtoReg, ALUOp.
- Opcode classes and latched selects {Reg2Loc, ALUSrc, MemtoReg, ALUOp}:
  - LDUR 11111000010 -> 0,1,1,00
  - STUR 11111000000 -> 1,1,0,00
  - CBZ 10110100xxx -> 1,0,0,01
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> 0,0,0,10
  - ERET 11010110100 -> 0,0,0,00
  - any other opcode -> INV, all selects 0
- State outputs (Moore; unlisted strobes are 0):
  - FETCH: IRWrite=1, PCWrite=1.
  - DECODE: no strobes.
  - EXEC: Branch=1 if CBZ; ERet=1 and PCWrite=1 if ERET.
  - MEM: MemRead=1 if LDUR, MemWrite=1 if STUR. Held for all 1+MEM_WAIT cycles.
  - WB: RegWrite=1.
  - EXC: Exc=1, PCWrite=1, exactly one cycle.
- State transitions:
  - FETCH -> DECODE.
  - DECODE -> EXC if Op is INV, else EXEC.
  - EXEC: R -> WB; LDUR/STUR -> MEM; CBZ/ERET -> end.
  - MEM: stays while wait counter < MEM_WAIT (counter increments each cycle, cleared on exit). LDUR -> WB; STUR -> end.
  - WB -> end.
  - EXC -> FETCH.
- "end" resolution: if IRQ_EN and ExtIRQ=1 in that cycle -> EXC, else -> FETCH.
- Exception causes: INV sets EStatus=1 (written on DECODE->EXC); IRQ sets EStatus=2 (written on end->EXC).
- Priority: INV is detected in DECODE, so no IRQ check applies on that path. An IRQ pending during EXC is not re-sampled until the next instruction's end.
- ERET does not clear EStatus. EStatus holds until the next exception or reset.
- Instruction lengths in cycles, including FETCH:
  - R: 4
  - LDUR: 5+MEM_WAIT
  - STUR: 4+MEM_WAIT
  - CBZ, ERET: 3
  - INV: 3 (FETCH, DECODE, EXC)
  - IRQ entry: +1 (EXC)
- Op changes after DECODE have no effect; the latch is used.

Test Plan:
- Reset, then ADD 10001011000, MEM_WAIT=0 -> FETCH(IRWrite=1, PCWrite=1), DECODE, EXEC, WB(RegWrite=1); selects=0,0,0,10; next FETCH at cycle 5.
- LDUR 11111000010 with MEM_WAIT=2 -> MemRead=1 for exactly 3 consecutive cycles, then RegWrite=1 one cycle, MemtoReg=1 throughout; total 7 cycles.
- STUR then CBZ 10110100011 -> STUR MemWrite=1 one cycle, no RegWrite; CBZ Branch=1 in its cycle 3, Reg2Loc=1, ALUOp=01.
- Op=11111111111 -> Exc=1 and PCWrite=1 in cycle 3, EStatus=0001; then ERET -> ERet=1 in its EXEC, EStatus still 0001.
- ExtIRQ=1 held during CBZ EXEC with IRQ_EN=1 -> EXC follows, EStatus=0010. Same stimulus with IRQ_EN=0 -> direct FETCH, EStatus unchanged.
- Assert reset during LDUR MEM wait -> all strobes 0 that cycle; FETCH with counter=0 after release; EStatus=0.

Source files
------------

// File: rtl/maindec_mc.sv
// Multi-cycle LEGv8 main decoder: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory wait states, ERET, and exception entry for invalid opcodes and IRQs.
module maindec_mc #(
  parameter int OP_W     = 11,
  parameter int MEM_WAIT = 0,
  parameter int IRQ_EN   = 1,
  parameter int ES_W     = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] Op,
  input  logic            ExtIRQ,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic            Reg2Loc,
  output logic            ALUSrc,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            Branch,
  output logic [1:0]      ALUOp,
  output logic            ERet,
  output logic            Exc,
  output logic [ES_W-1:0] EStatus,
  output logic            Busy
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_EXC} state_t;
  typedef enum logic [2:0] {C_R, C_LDUR, C_STUR, C_CBZ, C_ERET, C_INV} cls_t;
  typedef struct packed {
    cls_t       cls;
    logic       r2l;
    logic       alusrc;
    logic       mtr;
    logic [1:0] aluop;
  } dec_t;

  localparam logic [3:0] MW = MEM_WAIT[3:0];

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  dec_t            dec_q, dec_d, dec_new;
  logic [ES_W-1:0] es_q, es_d;
  logic [10:0]     op11;
  logic            end_x;
  logic irw, pcw, rw, mr, mw, br, er, exc;

  assign op11 = Op[OP_W-1 -: 11];

  always_comb begin
    dec_new     = '0;
    dec_new.cls = C_INV;
    if (op11 == 11'b11111000010) begin
      dec_new = '{cls: C_LDUR, r2l: 1'b0, alusrc: 1'b1, mtr: 1'b1, aluop: 2'b00};
    end else if (op11 == 11'b11111000000) begin
      dec_new = '{cls: C_STUR, r2l: 1'b1, alusrc: 1'b1, mtr: 1'b0, aluop: 2'b00};
    end else if (op11[10:3] == 8'b10110100) begin
      dec_new = '{cls: C_CBZ, r2l: 1'b1, alusrc: 1'b0, mtr: 1'b0, aluop: 2'b01};
    end else if (op11 == 11'b10001011000 || op11 == 11'b11001011000 ||
                 op11 == 11'b10001010000 || op11 == 11'b10101010000) begin
      dec_new = '{cls: C_R, r2l: 1'b0, alusrc: 1'b0, mtr: 1'b0, aluop: 2'b10};
    end else if (op11 == 11'b11010110100) begin
      dec_new = '{cls: C_ERET, r2l: 1'b0, alusrc: 1'b0, mtr: 1'b0, aluop: 2'b00};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    es_d    = es_q;
    end_x   = 1'b0;
    irw = 1'b0; pcw = 1'b0; rw = 1'b0; mr = 1'b0;
    mw  = 1'b0; br  = 1'b0; er = 1'b0; exc = 1'b0;
    case (state_q)
      S_FETCH: begin
        irw = 1'b1; pcw = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        dec_d = dec_new;
        if (dec_new.cls == C_INV) begin
          state_d = S_EXC;
          es_d    = ES_W'(1);
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (dec_q.cls)
          C_R:            state_d = S_WB;
          C_LDUR, C_STUR: state_d = S_MEM;
          C_CBZ:  begin br = 1'b1; end_x = 1'b1; end
          C_ERET: begin er = 1'b1; pcw = 1'b1; end_x = 1'b1; end
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mr = (dec_q.cls == C_LDUR);
        mw = (dec_q.cls == C_STUR);
        if (cnt_q < MW) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cnt_d = 4'd0;
          if (dec_q.cls == C_LDUR) state_d = S_WB;
          else                     end_x = 1'b1;
        end
      end
      S_WB: begin
        rw = 1'b1; end_x = 1'b1;
      end
      S_EXC: begin
        exc = 1'b1; pcw = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Instruction completion: IRQ entry takes one extra EXC cycle.
    if (end_x) begin
      if (IRQ_EN != 0 && ExtIRQ) begin
        state_d = S_EXC;
        es_d    = ES_W'(2);
      end else begin
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= 4'd0;
      dec_q   <= '0;
      es_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      es_q    <= es_d;
    end
  end

  assign IRWrite  = irw & ~reset;
  assign PCWrite  = pcw & ~reset;
  assign RegWrite = rw  & ~reset;
  assign MemRead  = mr  & ~reset;
  assign MemWrite = mw  & ~reset;
  assign Branch   = br  & ~reset;
  assign ERet     = er  & ~reset;
  assign Exc      = exc & ~reset;
  assign Busy     = (state_q != S_FETCH) & ~reset;
  assign Reg2Loc  = dec_q.r2l;
  assign ALUSrc   = dec_q.alusrc;
  assign MemtoReg = dec_q.mtr;
  assign ALUOp    = dec_q.aluop;
  assign EStatus  = es_q;

endmodule

// File: tb/tb_maindec_mc.sv
// Directed bench for maindec_mc: per-cycle vector table on the MEM_WAIT=0 core,
// plus hand sequences for MEM_WAIT=2 timing, reset abort and IRQ_EN=0.
module tb_maindec_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // strobe vector order: {IRWrite,PCWrite,RegWrite,MemRead,MemWrite,Branch,ERet,Exc,Busy}
  localparam logic [8:0] S0 = 9'b000000000;
  localparam logic [8:0] SF = 9'b110000000;
  localparam logic [8:0] SD = 9'b000000001;
  localparam logic [8:0] SR = 9'b001000001;
  localparam logic [8:0] SM = 9'b000100001;
  localparam logic [8:0] SW = 9'b000010001;
  localparam logic [8:0] SB = 9'b000001001;
  localparam logic [8:0] SE = 9'b010000101;
  localparam logic [8:0] SX = 9'b010000011;

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] CBZ  = 11'b10110100011;
  localparam logic [10:0] ERET = 11'b11010110100;
  localparam logic [10:0] BAD  = 11'b11111111111;

  typedef struct packed {
    logic        rst;
    logic [10:0] op;
    logic        irq;
    logic [8:0]  s;
    logic        chk_sel;
    logic [4:0]  sel;
    logic [3:0]  es;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic        rst, irq, rst2, irq2;
  logic [10:0] op, op2;

  logic irw0, pcw0, r2l0, als0, mtr0, rw0, mr0, mw0, br0, er0, ex0, bz0;
  logic [1:0] alu0;
  logic [3:0] es0;
  logic irw2, pcw2, r2l2, als2, mtr2, rw2, mr2, mw2, br2, er2, ex2, bz2;
  logic [1:0] alu2;
  logic [3:0] es2;
  logic irwn, pcwn, r2ln, alsn, mtrn, rwn, mrn, mwn, brn, ern, exn, bzn;
  logic [1:0] alun;
  logic [3:0] esn;

  maindec_mc #(.OP_W(11), .MEM_WAIT(0), .IRQ_EN(1), .ES_W(4)) d0 (
    .clk(clk), .reset(rst), .Op(op), .ExtIRQ(irq),
    .IRWrite(irw0), .PCWrite(pcw0), .Reg2Loc(r2l0), .ALUSrc(als0), .MemtoReg(mtr0),
    .RegWrite(rw0), .MemRead(mr0), .MemWrite(mw0), .Branch(br0), .ALUOp(alu0),
    .ERet(er0), .Exc(ex0), .EStatus(es0), .Busy(bz0));

  maindec_mc #(.OP_W(11), .MEM_WAIT(2), .IRQ_EN(1), .ES_W(4)) d2 (
    .clk(clk), .reset(rst2), .Op(op2), .ExtIRQ(irq2),
    .IRWrite(irw2), .PCWrite(pcw2), .Reg2Loc(r2l2), .ALUSrc(als2), .MemtoReg(mtr2),
    .RegWrite(rw2), .MemRead(mr2), .MemWrite(mw2), .Branch(br2), .ALUOp(alu2),
    .ERet(er2), .Exc(ex2), .EStatus(es2), .Busy(bz2));

  maindec_mc #(.OP_W(11), .MEM_WAIT(0), .IRQ_EN(0), .ES_W(4)) dn (
    .clk(clk), .reset(rst), .Op(op), .ExtIRQ(irq),
    .IRWrite(irwn), .PCWrite(pcwn), .Reg2Loc(r2ln), .ALUSrc(alsn), .MemtoReg(mtrn),
    .RegWrite(rwn), .MemRead(mrn), .MemWrite(mwn), .Branch(brn), .ALUOp(alun),
    .ERet(ern), .Exc(exn), .EStatus(esn), .Busy(bzn));

  wire [8:0] s0  = {irw0, pcw0, rw0, mr0, mw0, br0, er0, ex0, bz0};
  wire [8:0] s2  = {irw2, pcw2, rw2, mr2, mw2, br2, er2, ex2, bz2};
  wire [8:0] sn  = {irwn, pcwn, rwn, mrn, mwn, brn, ern, exn, bzn};
  wire [4:0] sel0 = {r2l0, als0, mtr0, alu0};

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic nx();
    @(posedge clk); #1;
  endtask

  // One cycle of the MEM_WAIT=2 core: check strobes (and optionally EStatus/MemtoReg) then advance.
  task automatic step2(input string nm, input logic [8:0] e, input logic ces,
                       input logic [3:0] ees, input logic cm);
    @(negedge clk);
    check({nm, " strobes"}, {7'd0, s2}, {7'd0, e});
    if (ces) check({nm, " EStatus"}, {12'd0, es2}, {12'd0, ees});
    if (cm)  check({nm, " MemtoReg"}, {15'd0, mtr2}, 16'd1);
    nx();
  endtask

  function automatic vec_t mk(input logic r, input logic [10:0] o, input logic q,
                              input logic [8:0] s, input logic c, input logic [4:0] sl,
                              input logic [3:0] e);
    mk = '{rst: r, op: o, irq: q, s: s, chk_sel: c, sel: sl, es: e};
  endfunction

  vec_t tbl [32];

  initial begin
    tbl[0]  = mk(1, ADD,  0, S0, 0, 5'b00000, 4'd0);
    tbl[1]  = mk(0, ADD,  0, SF, 0, 5'b00000, 4'd0);
    tbl[2]  = mk(0, ADD,  0, SD, 0, 5'b00000, 4'd0);
    tbl[3]  = mk(0, BAD,  0, SD, 1, 5'b00010, 4'd0); // Op changes after DECODE
    tbl[4]  = mk(0, BAD,  0, SR, 1, 5'b00010, 4'd0);
    tbl[5]  = mk(0, LDUR, 0, SF, 0, 5'b00000, 4'd0);
    tbl[6]  = mk(0, LDUR, 0, SD, 0, 5'b00000, 4'd0);
    tbl[7]  = mk(0, LDUR, 0, SD, 1, 5'b01100, 4'd0);
    tbl[8]  = mk(0, LDUR, 0, SM, 1, 5'b01100, 4'd0);
    tbl[9]  = mk(0, LDUR, 0, SR, 1, 5'b01100, 4'd0);
    tbl[10] = mk(0, STUR, 0, SF, 0, 5'b00000, 4'd0);
    tbl[11] = mk(0, STUR, 0, SD, 0, 5'b00000, 4'd0);
    tbl[12] = mk(0, STUR, 0, SD, 1, 5'b11000, 4'd0);
    tbl[13] = mk(0, STUR, 0, SW, 1, 5'b11000, 4'd0);
    tbl[14] = mk(0, CBZ,  0, SF, 0, 5'b00000, 4'd0);
    tbl[15] = mk(0, CBZ,  0, SD, 0, 5'b00000, 4'd0);
    tbl[16] = mk(0, CBZ,  0, SB, 1, 5'b10001, 4'd0);
    tbl[17] = mk(0, BAD,  0, SF, 0, 5'b00000, 4'd0);
    tbl[18] = mk(0, BAD,  0, SD, 0, 5'b00000, 4'd0);
    tbl[19] = mk(0, BAD,  0, SX, 1, 5'b00000, 4'd1);
    tbl[20] = mk(0, ERET, 0, SF, 0, 5'b00000, 4'd1);
    tbl[21] = mk(0, ERET, 0, SD, 0, 5'b00000, 4'd1);
    tbl[22] = mk(0, ERET, 0, SE, 1, 5'b00000, 4'd1);
    tbl[23] = mk(0, CBZ,  0, SF, 0, 5'b00000, 4'd1);
    tbl[24] = mk(0, CBZ,  0, SD, 0, 5'b00000, 4'd1);
    tbl[25] = mk(0, CBZ,  1, SB, 1, 5'b10001, 4'd1);
    tbl[26] = mk(0, ADD,  1, SX, 0, 5'b00000, 4'd2); // IRQ still high in EXC
    tbl[27] = mk(0, ADD,  0, SF, 0, 5'b00000, 4'd2);
    tbl[28] = mk(0, ADD,  0, SD, 0, 5'b00000, 4'd2);
    tbl[29] = mk(0, ADD,  0, SD, 1, 5'b00010, 4'd2);
    tbl[30] = mk(0, ADD,  1, SR, 1, 5'b00010, 4'd2);
    tbl[31] = mk(0, ADD,  0, SX, 0, 5'b00000, 4'd2);

    rst = 1'b1; irq = 1'b0; op = ADD;
    rst2 = 1'b1; irq2 = 1'b0; op2 = BAD;
    nx(); nx();

    for (int i = 0; i < 32; i++) begin
      rst = tbl[i].rst; op = tbl[i].op; irq = tbl[i].irq;
      @(negedge clk);
      check($sformatf("row%0d strobes", i), {7'd0, s0}, {7'd0, tbl[i].s});
      check($sformatf("row%0d EStatus", i), {12'd0, es0}, {12'd0, tbl[i].es});
      if (tbl[i].chk_sel) check($sformatf("row%0d selects", i), {11'd0, sel0}, {11'd0, tbl[i].sel});
      if (i == 26) begin
        check("noirq strobes", {7'd0, sn}, {7'd0, SF});
        check("noirq EStatus", {12'd0, esn}, 16'd1);
      end
      nx();
    end

    // MEM_WAIT=2: INV, then LDUR with 3 MEM cycles (7 total), then reset inside MEM wait.
    rst2 = 1'b0; op2 = BAD;
    step2("w2 inv fetch", SF, 1, 4'd0, 0);
    step2("w2 inv decode", SD, 0, 4'd0, 0);
    step2("w2 inv exc", SX, 1, 4'd1, 0);
    op2 = LDUR;
    step2("w2 ld fetch", SF, 0, 4'd0, 0);
    step2("w2 ld decode", SD, 0, 4'd0, 0);
    step2("w2 ld exec", SD, 0, 4'd0, 1);
    for (int k = 0; k < 3; k++) step2($sformatf("w2 ld mem%0d", k), SM, 0, 4'd0, 1);
    step2("w2 ld wb", SR, 0, 4'd0, 1);
    step2("w2 ld next fetch", SF, 1, 4'd1, 0);
    step2("w2 ld2 decode", SD, 0, 4'd0, 0);
    step2("w2 ld2 exec", SD, 0, 4'd0, 0);
    step2("w2 ld2 mem0", SM, 0, 4'd0, 0);
    rst2 = 1'b1;
    step2("w2 reset mid-mem", S0, 0, 4'd0, 0);
    rst2 = 1'b0; op2 = STUR;
    step2("w2 post-reset fetch", SF, 1, 4'd0, 0);
    step2("w2 st decode", SD, 0, 4'd0, 0);
    step2("w2 st exec", SD, 0, 4'd0, 0);
    for (int k = 0; k < 3; k++) step2($sformatf("w2 st mem%0d", k), SW, 0, 4'd0, 0);
    step2("w2 st next fetch", SF, 1, 4'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
